// File: rtl/axi_mem_arbiter.sv
// Round-robin sharing of the single AXI master connector between the core data port (0)
// and the CGRA load/store unit (1): stall rise/fall sequencing plus a hung-slave timeout.
module axi_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [4:0]  len0,
  input  logic [4:0]  len1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        mem_write,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic [4:0]  mem_length,
  input  logic        mem_stall,
  input  logic [31:0] mem_rdata,
  output logic        arb_busy
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             last, last_nxt, sel, sel_nxt, win;
  logic             mem_write_nxt, mem_read_nxt;
  logic [31:0]      mem_addr_nxt, mem_data_nxt;
  logic [4:0]       mem_length_nxt;
  logic [1:0]       gnt_nxt, done_nxt, err_nxt;
  logic [1:0][31:0] rdata_nxt;
  logic             fall, timeout;

  logic [1:0]       req, we;
  logic [1:0][31:0] addr, wdata;
  logic [1:0][4:0]  len;

  assign req   = {req1, req0};
  assign we    = {we1, we0};
  assign addr  = {addr1, addr0};
  assign wdata = {wdata1, wdata0};
  assign len   = {len1, len0};

  // A fall only counts once the stall has been seen high, i.e. from BUSY.
  assign fall    = (state == BUSY) && !mem_stall;
  assign timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_nxt       = last;
    sel_nxt        = sel;
    mem_write_nxt  = mem_write;
    mem_read_nxt   = mem_read;
    mem_addr_nxt   = mem_addr;
    mem_data_nxt   = mem_data;
    mem_length_nxt = mem_length;
    gnt_nxt        = {gnt1, gnt0};
    done_nxt       = '0;
    err_nxt        = '0;
    rdata_nxt      = {rdata1, rdata0};
    // Lone requester wins; on a tie the port that did not go last wins.
    win            = req[1] & (~req[0] | ~last);
    case (state)
      IDLE: begin
        if (|req) begin
          sel_nxt        = win;
          last_nxt       = win;
          gnt_nxt        = win ? 2'b10 : 2'b01;
          mem_write_nxt  = we[win];
          mem_read_nxt   = ~we[win];
          mem_addr_nxt   = addr[win];
          mem_data_nxt   = wdata[win];
          mem_length_nxt = (len[win] == 5'd0) ? 5'd1 : len[win];
          cnt_nxt        = '0;
          state_nxt      = ISSUE;
        end
      end
      ISSUE, BUSY: begin
        cnt_nxt = cnt + CW'(1);
        if (fall || timeout) begin
          state_nxt     = DONE;
          mem_write_nxt = 1'b0;
          mem_read_nxt  = 1'b0;
          done_nxt[sel] = 1'b1;
          if (fall) begin
            if (mem_read) rdata_nxt[sel] = mem_rdata;
          end else begin
            err_nxt[sel] = 1'b1;
          end
        end else if (state == ISSUE && mem_stall) begin
          state_nxt = BUSY;
        end
      end
      DONE: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last       <= 1'b1;
      sel        <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      mem_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_length <= '0;
      arb_busy   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last       <= last_nxt;
      sel        <= sel_nxt;
      gnt0       <= gnt_nxt[0];
      gnt1       <= gnt_nxt[1];
      done0      <= done_nxt[0];
      done1      <= done_nxt[1];
      err0       <= err_nxt[0];
      err1       <= err_nxt[1];
      rdata0     <= rdata_nxt[0];
      rdata1     <= rdata_nxt[1];
      mem_write  <= mem_write_nxt;
      mem_read   <= mem_read_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_data   <= mem_data_nxt;
      mem_length <= mem_length_nxt;
      arb_busy   <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Randomized bench for axi_mem_arbiter: transaction-level round-robin/latency model plus
// a connector model that raises and drops stall after a chosen number of cycles.
module tb_axi_mem_arbiter;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        t_req[2];
  logic        t_we[2];
  logic [31:0] t_addr[2];
  logic [31:0] t_wdata[2];
  logic [4:0]  t_len[2];
  logic        mem_stall;
  logic [31:0] mem_rdata;

  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_write, mem_read;
  logic [31:0] mem_addr, mem_data;
  logic [4:0]  mem_length;
  logic        arb_busy;

  axi_mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .req0(t_req[0]), .req1(t_req[1]),
    .we0(t_we[0]), .we1(t_we[1]),
    .addr0(t_addr[0]), .addr1(t_addr[1]),
    .wdata0(t_wdata[0]), .wdata1(t_wdata[1]),
    .len0(t_len[0]), .len1(t_len[1]),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1),
    .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_length(mem_length),
    .mem_stall(mem_stall), .mem_rdata(mem_rdata),
    .arb_busy(arb_busy)
  );

  int          n_chk = 0;
  int          n_err = 0;
  int          last_m, cur, exp_cycles, cmd_cnt, low_cnt, d_cur, k_cur, d_set, k_set;
  bit          c_hang, exp_err, exp_we, post_done, seen_fall, rv_fix_en;
  bit [1:0]    pend;
  logic [31:0] rv, rv_fix;
  logic [31:0] rdata_m[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    cur = -1; last_m = 1; pend = 2'b00; post_done = 0; seen_fall = 0;
    low_cnt = 0; cmd_cnt = 0; rdata_m[0] = '0; rdata_m[1] = '0;
  endtask

  task automatic rnd_port(input int p);
    t_we[p]    = 1'($urandom);
    t_addr[p]  = $urandom;
    t_wdata[p] = $urandom;
    t_len[p]   = 5'($urandom);
  endtask

  // One negedge observation: check outputs against the model, then drive the connector.
  task automatic step();
    logic cmd;
    int   w;
    cmd = mem_read | mem_write;
    if (post_done) begin
      chk("gnt_drop", {30'b0, gnt1, gnt0}, 0);
      chk("done_pulse", {30'b0, done1, done0}, 0);
      post_done = 0;
    end
    if (cur < 0 && (gnt0 | gnt1)) begin
      w = (pend == 2'b11) ? (last_m == 0 ? 1 : 0) : (pend[0] ? 0 : 1);
      chk("gnt_port", {30'b0, gnt1, gnt0}, w ? 2 : 1);
      cur = w; last_m = w; exp_we = t_we[w];
      chk("mem_addr", mem_addr, t_addr[w]);
      chk("mem_data", mem_data, t_wdata[w]);
      chk("mem_length", {27'b0, mem_length}, t_len[w] == 5'd0 ? 1 : {27'b0, t_len[w]});
      chk("mem_cmd", {30'b0, mem_write, mem_read}, t_we[w] ? 2 : 1);
      if (seen_fall) chk("cmd_gap", {31'b0, low_cnt >= 2}, 1);
      d_cur = (d_set < 0) ? $urandom_range(0, 2) : d_set;
      k_cur = (k_set < 0) ? $urandom_range(1, 3) : k_set;
      exp_cycles = c_hang ? T : d_cur + k_cur + 1;
      exp_err = c_hang;
      rv = rv_fix_en ? rv_fix : $urandom;
      cmd_cnt = 0;
    end
    if (cmd) begin cmd_cnt++; low_cnt = 0; end
    else low_cnt++;
    chk("rw_excl", {31'b0, mem_read & mem_write}, 0);
    chk("arb_busy", {31'b0, arb_busy}, cur >= 0 ? 1 : 0);
    if (done0 | done1) begin
      chk("done_port", {30'b0, done1, done0}, cur == 1 ? 2 : (cur == 0 ? 1 : 0));
      chk("cmd_low", {31'b0, cmd}, 0);
      if (cur >= 0) begin
        chk("cmd_cycles", cmd_cnt, exp_cycles);
        chk("err", {30'b0, err1, err0}, exp_err ? (cur == 1 ? 2 : 1) : 0);
        chk("gnt_hold", {30'b0, gnt1, gnt0}, cur == 1 ? 2 : 1);
        if (!exp_we && !exp_err) rdata_m[cur] = rv;
        chk("rdata0", rdata0, rdata_m[0]);
        chk("rdata1", rdata1, rdata_m[1]);
        t_req[cur] = 1'b0;
        pend[cur] = 1'b0;
      end
      cur = -1; post_done = 1; seen_fall = 1;
    end else begin
      chk("err_idle", {30'b0, err1, err0}, 0);
    end
    if (cur >= 0 && cmd && !c_hang) begin
      if (cmd_cnt == d_cur + 1) begin mem_stall = 1'b1; mem_rdata = $urandom; end
      if (cmd_cnt == d_cur + 1 + k_cur) begin mem_stall = 1'b0; mem_rdata = rv; end
    end else if (!cmd) begin
      mem_stall = 1'b0;
    end
  endtask

  task automatic run_round(input bit [1:0] mask);
    for (int p = 0; p < 2; p++) if (mask[p]) t_req[p] = 1'b1;
    pend = pend | mask;
    for (int c = 0; c < 300 && pend != 2'b00; c++) begin
      @(negedge clk);
      step();
    end
    chk("round_end", {30'b0, pend}, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, {30'b0, gnt1, gnt0}, 0);
    chk({tag, "_done"}, {28'b0, done1, done0, err1, err0}, 0);
    chk({tag, "_cmd"}, {29'b0, mem_write, mem_read, arb_busy}, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_data"}, mem_data, 0);
    chk({tag, "_len"}, {27'b0, mem_length}, 0);
    chk({tag, "_rdata0"}, rdata0, 0);
    chk({tag, "_rdata1"}, rdata1, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit [1:0] mask;
    model_reset();
    for (int p = 0; p < 2; p++) begin
      t_req[p] = 1'b0; t_we[p] = 1'b0; t_addr[p] = '0; t_wdata[p] = '0; t_len[p] = '0;
    end
    mem_stall = 1'b0; mem_rdata = '0;
    d_set = -1; k_set = -1; c_hang = 0; rv_fix_en = 0; rv_fix = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;

    // Directed read on port 0: stall rises one cycle in, held 3 cycles.
    t_we[0] = 1'b0; t_addr[0] = 32'h100; t_wdata[0] = '0; t_len[0] = 5'd1;
    d_set = 1; k_set = 3; rv_fix_en = 1; rv_fix = 32'hDEADBEEF;
    run_round(2'b01);
    chk("rd_beef", rdata0, 32'hDEADBEEF);
    rv_fix_en = 0; d_set = -1; k_set = -1;

    // Write bursts on port 1, then the len=0 case.
    t_we[1] = 1'b1; t_addr[1] = 32'h2000; t_wdata[1] = 32'h5; t_len[1] = 5'd5;
    run_round(2'b10);
    t_len[1] = 5'd0;
    run_round(2'b10);

    // Contention: both ports held high.
    for (int i = 0; i < 2; i++) begin
      rnd_port(0); rnd_port(1);
      run_round(2'b11);
    end

    // Hung slave, then a normal request.
    rnd_port(0); t_we[0] = 1'b0; c_hang = 1;
    run_round(2'b01);
    c_hang = 0;
    rnd_port(0);
    run_round(2'b01);

    for (int i = 0; i < 24; i++) begin
      mask = 2'($urandom_range(1, 3));
      rnd_port(0); rnd_port(1);
      c_hang = ($urandom_range(0, 5) == 0);
      run_round(mask);
      c_hang = 0;
    end

    // Asynchronous reset while in BUSY.
    rnd_port(0); t_we[0] = 1'b0; d_set = 0; k_set = 6;
    t_req[0] = 1'b1; pend = 2'b01;
    for (int c = 0; c < 50 && !(cur == 0 && cmd_cnt == 3); c++) begin
      @(negedge clk);
      step();
    end
    chk("rst_setup", cmd_cnt, 3);
    #2 rst = 1'b0;
    #1 chk_all_zero("async_rst");
    t_req[0] = 1'b0; mem_stall = 1'b0; d_set = -1; k_set = -1;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    rnd_port(0); rnd_port(1);
    run_round(2'b11);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
